// File: rtl/xlr8_text_pkg.sv
// Shared constants and types for the text RAM port-A scheduler.
package xlr8_text_pkg;

  localparam int TEXT_COLS  = 80;
  localparam int TEXT_ROWS  = 30;
  localparam int TEXT_CELLS = TEXT_COLS * TEXT_ROWS;

  typedef logic [12:0] text_addr_t;

  typedef enum logic [2:0] {
    ENG_IDLE,
    ENG_FILL,
    ENG_SCR_RD,
    ENG_SCR_WR,
    ENG_SCR_BLANK
  } eng_state_t;

endpackage

// File: rtl/xlr8_text_engine.sv
// Fill / scroll-up engine. Requests port A and advances only on granted cycles.
module xlr8_text_engine
  import xlr8_text_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int COLS   = TEXT_COLS,
  parameter int ROWS   = TEXT_ROWS
) (
  input  logic              clk_pixel,
  input  logic              rst,
  input  logic              cmd_fill,
  input  logic              cmd_scroll,
  input  logic [7:0]        fill_char,
  input  logic [7:0]        fill_attr,
  input  logic              gnt,
  input  logic [7:0]        ram_char_q,
  input  logic [7:0]        ram_attr_q,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        char_wdata,
  output logic [7:0]        attr_wdata,
  output logic              we,
  output logic              rd,
  output logic              busy,
  output logic              done
);

  localparam int CELLS = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] LAST_COPY = ADDR_W'((ROWS - 1) * COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);

  eng_state_t        state, state_nxt;
  logic [ADDR_W-1:0] a, a_nxt;
  logic [7:0]        cp_char, cp_attr;
  logic              cp_lat;   // a scroll read was granted last cycle; ram_*_q holds it now

  // State, address and copy register; the copy latches even if the write is stalled.
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      state   <= ENG_IDLE;
      a       <= '0;
      cp_lat  <= 1'b0;
      cp_char <= '0;
      cp_attr <= '0;
    end else begin
      state  <= state_nxt;
      a      <= a_nxt;
      cp_lat <= gnt && (state == ENG_SCR_RD);
      if (cp_lat) begin
        cp_char <= ram_char_q;
        cp_attr <= ram_attr_q;
      end
    end
  end

  // Next state and port-A request. A write granted right after its read bypasses the copy reg.
  always_comb begin
    state_nxt  = state;
    a_nxt      = a;
    req        = 1'b0;
    addr       = a;
    we         = 1'b0;
    rd         = 1'b0;
    char_wdata = fill_char;
    attr_wdata = fill_attr;
    done       = 1'b0;
    case (state)
      ENG_IDLE: begin
        if (cmd_fill) begin
          state_nxt = ENG_FILL;
          a_nxt     = '0;
        end else if (cmd_scroll) begin
          state_nxt = ENG_SCR_RD;
          a_nxt     = '0;
        end
      end
      ENG_FILL, ENG_SCR_BLANK: begin
        req = 1'b1;
        we  = 1'b1;
        if (gnt) begin
          a_nxt = a + 1'b1;
          if (a == LAST_CELL) begin
            state_nxt = ENG_IDLE;
            done      = 1'b1;
          end
        end
      end
      ENG_SCR_RD: begin
        req  = 1'b1;
        rd   = 1'b1;
        addr = a + ROW_STEP;
        if (gnt) state_nxt = ENG_SCR_WR;
      end
      ENG_SCR_WR: begin
        req        = 1'b1;
        we         = 1'b1;
        char_wdata = cp_lat ? ram_char_q : cp_char;
        attr_wdata = cp_lat ? ram_attr_q : cp_attr;
        if (gnt) begin
          a_nxt     = a + 1'b1;
          state_nxt = (a == LAST_COPY) ? ENG_SCR_BLANK : ENG_SCR_RD;
        end
      end
      default: state_nxt = ENG_IDLE;
    endcase
  end

  assign busy = (state != ENG_IDLE);

endmodule

// File: rtl/xlr8_text_ram_sched.sv
// Port-A scheduler for the char/attr text RAMs: AVR write slot, auto-increment pointer,
// read prefetch and the fill/scroll engine, fixed priority slot > prefetch > engine.
module xlr8_text_ram_sched
  import xlr8_text_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int COLS   = TEXT_COLS,
  parameter int ROWS   = TEXT_ROWS
) (
  input  logic              clk_pixel,
  input  logic              rst,
  input  logic              clken,
  input  logic [7:0]        avr_wdata,
  input  logic              avr_addr_lo_we,
  input  logic              avr_addr_hi_we,
  input  logic              avr_char_we,
  input  logic              avr_attr_we,
  input  logic              avr_attr_re,
  output logic [ADDR_W-1:0] avr_addr,
  output logic [7:0]        avr_char_rdata,
  output logic [7:0]        avr_attr_rdata,
  output logic              avr_rd_valid,
  input  logic              cmd_fill,
  input  logic              cmd_scroll,
  input  logic [7:0]        fill_char,
  input  logic [7:0]        fill_attr,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_char_wdata,
  output logic [7:0]        ram_attr_wdata,
  output logic              ram_char_we,
  output logic              ram_attr_we,
  output logic              ram_rden,
  input  logic [7:0]        ram_char_q,
  input  logic [7:0]        ram_attr_q
);

  localparam int CELLS = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              slot_vld, slot_cwe, slot_awe;
  logic [ADDR_W-1:0] slot_addr;
  logic [7:0]        slot_wdata;
  logic              pf_pend, pf_inflight, pf_issue;
  logic              stb_any, stb_wr, stb_inc, touch;

  logic              eng_req, eng_gnt, eng_we, eng_rd, eng_done;
  logic [ADDR_W-1:0] eng_addr;
  logic [7:0]        eng_char, eng_attr;

  assign stb_any  = clken & (avr_addr_lo_we | avr_addr_hi_we | avr_char_we |
                             avr_attr_we | avr_attr_re);
  assign stb_wr   = clken & (avr_char_we | avr_attr_we);
  assign stb_inc  = clken & (avr_attr_we | avr_attr_re);
  assign touch    = stb_any | eng_done;
  assign pf_issue = pf_pend & ~slot_vld;
  assign eng_gnt  = eng_req & ~slot_vld & ~pf_pend;
  assign avr_addr = ptr;

  // Pointer next value: wrap-increment first, then any byte loads override (no clamping).
  always_comb begin
    ptr_nxt = ptr;
    if (stb_inc) ptr_nxt = (ptr == LAST_CELL) ? '0 : ptr + 1'b1;
    if (clken && avr_addr_lo_we) ptr_nxt[7:0] = avr_wdata;
    if (clken && avr_addr_hi_we) ptr_nxt[ADDR_W-1:8] = avr_wdata[ADDR_W-9:0];
  end

  // Pointer and one-entry write slot; the slot captures the pre-increment pointer.
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      ptr        <= '0;
      slot_vld   <= 1'b0;
      slot_cwe   <= 1'b0;
      slot_awe   <= 1'b0;
      slot_addr  <= '0;
      slot_wdata <= '0;
    end else begin
      ptr        <= ptr_nxt;
      slot_vld   <= stb_wr;
      slot_cwe   <= clken & avr_char_we;
      slot_awe   <= clken & avr_attr_we;
      slot_addr  <= ptr;
      slot_wdata <= avr_wdata;
    end
  end

  // Prefetch: any touch drops valid, requeues a read and discards one already in flight.
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      pf_pend        <= 1'b0;
      pf_inflight    <= 1'b0;
      avr_rd_valid   <= 1'b0;
      avr_char_rdata <= '0;
      avr_attr_rdata <= '0;
    end else begin
      if (pf_inflight) begin
        avr_char_rdata <= ram_char_q;
        avr_attr_rdata <= ram_attr_q;
        avr_rd_valid   <= 1'b1;
      end
      pf_inflight <= pf_issue;
      if (pf_issue) pf_pend <= 1'b0;
      if (touch) begin
        avr_rd_valid <= 1'b0;
        pf_pend      <= 1'b1;
        pf_inflight  <= 1'b0;
      end
    end
  end

  // Fixed-priority port-A mux.
  always_comb begin
    ram_addr       = eng_addr;
    ram_char_wdata = eng_char;
    ram_attr_wdata = eng_attr;
    ram_char_we    = 1'b0;
    ram_attr_we    = 1'b0;
    ram_rden       = 1'b0;
    if (slot_vld) begin
      ram_addr       = slot_addr;
      ram_char_wdata = slot_wdata;
      ram_attr_wdata = slot_wdata;
      ram_char_we    = slot_cwe;
      ram_attr_we    = slot_awe;
    end else if (pf_pend) begin
      ram_addr = ptr;
      ram_rden = 1'b1;
    end else if (eng_req) begin
      ram_char_we = eng_we;
      ram_attr_we = eng_we;
      ram_rden    = eng_rd;
    end
  end

  xlr8_text_engine #(.ADDR_W(ADDR_W), .COLS(COLS), .ROWS(ROWS)) u_engine (
    .clk_pixel  (clk_pixel),
    .rst        (rst),
    .cmd_fill   (cmd_fill),
    .cmd_scroll (cmd_scroll),
    .fill_char  (fill_char),
    .fill_attr  (fill_attr),
    .gnt        (eng_gnt),
    .ram_char_q (ram_char_q),
    .ram_attr_q (ram_attr_q),
    .req        (eng_req),
    .addr       (eng_addr),
    .char_wdata (eng_char),
    .attr_wdata (eng_attr),
    .we         (eng_we),
    .rd         (eng_rd),
    .busy       (busy),
    .done       (eng_done)
  );

endmodule

// File: tb/tb_xlr8_text_ram_sched.sv
// Bench for xlr8_text_ram_sched: RAM model, pointer/slot model checked every cycle,
// directed scenarios with literal expectations.
module tb_xlr8_text_ram_sched;

  logic        clk_pixel = 1'b0;
  logic        rst = 1'b1;
  logic        clken = 1'b0;
  logic [7:0]  avr_wdata = '0;
  logic        avr_addr_lo_we = 1'b0, avr_addr_hi_we = 1'b0;
  logic        avr_char_we = 1'b0, avr_attr_we = 1'b0, avr_attr_re = 1'b0;
  logic [12:0] avr_addr;
  logic [7:0]  avr_char_rdata, avr_attr_rdata;
  logic        avr_rd_valid;
  logic        cmd_fill = 1'b0, cmd_scroll = 1'b0;
  logic [7:0]  fill_char = '0, fill_attr = '0;
  logic        busy;
  logic [12:0] ram_addr;
  logic [7:0]  ram_char_wdata, ram_attr_wdata;
  logic        ram_char_we, ram_attr_we, ram_rden;
  logic [7:0]  ram_char_q = '0, ram_attr_q = '0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk_pixel = ~clk_pixel;

  xlr8_text_ram_sched dut (
    .clk_pixel      (clk_pixel),
    .rst            (rst),
    .clken          (clken),
    .avr_wdata      (avr_wdata),
    .avr_addr_lo_we (avr_addr_lo_we),
    .avr_addr_hi_we (avr_addr_hi_we),
    .avr_char_we    (avr_char_we),
    .avr_attr_we    (avr_attr_we),
    .avr_attr_re    (avr_attr_re),
    .avr_addr       (avr_addr),
    .avr_char_rdata (avr_char_rdata),
    .avr_attr_rdata (avr_attr_rdata),
    .avr_rd_valid   (avr_rd_valid),
    .cmd_fill       (cmd_fill),
    .cmd_scroll     (cmd_scroll),
    .fill_char      (fill_char),
    .fill_attr      (fill_attr),
    .busy           (busy),
    .ram_addr       (ram_addr),
    .ram_char_wdata (ram_char_wdata),
    .ram_attr_wdata (ram_attr_wdata),
    .ram_char_we    (ram_char_we),
    .ram_attr_we    (ram_attr_we),
    .ram_rden       (ram_rden),
    .ram_char_q     (ram_char_q),
    .ram_attr_q     (ram_attr_q)
  );

  // RAM model with a backdoor port used only while the scheduler is idle or in reset.
  logic [7:0]  cmem [0:8191];
  logic [7:0]  amem [0:8191];
  logic        bd_we = 1'b0;
  logic [12:0] bd_addr = '0;
  logic [7:0]  bd_c = '0, bd_a = '0;

  always @(posedge clk_pixel) begin
    if (bd_we) begin
      cmem[bd_addr] <= bd_c;
      amem[bd_addr] <= bd_a;
    end else begin
      if (ram_char_we) cmem[ram_addr] <= ram_char_wdata;
      if (ram_attr_we) amem[ram_addr] <= ram_attr_wdata;
    end
    if (ram_rden) begin
      ram_char_q <= cmem[ram_addr];
      ram_attr_q <= amem[ram_addr];
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Behavioural model: the AVR pointer and the write each qualified strobe must produce next cycle.
  logic [12:0] m_ptr = '0;
  logic        exp_wr = 1'b0, exp_cwe = 1'b0, exp_awe = 1'b0;
  logic [12:0] exp_wa = '0;
  logic [7:0]  exp_wd = '0;
  logic        started = 1'b0;
  logic        chk_rd = 1'b1;

  function automatic logic [12:0] model_next(input logic [12:0] p);
    logic [12:0] n;
    n = p;
    if (clken && (avr_attr_we || avr_attr_re)) n = (int'(p) == 2399) ? 13'd0 : p + 13'd1;
    if (clken && avr_addr_lo_we) n = {n[12:8], avr_wdata};
    if (clken && avr_addr_hi_we) n = {avr_wdata[4:0], n[7:0]};
    return n;
  endfunction

  always @(posedge clk_pixel) begin
    if (rst) begin
      m_ptr  <= '0;
      exp_wr <= 1'b0;
    end else begin
      m_ptr   <= model_next(m_ptr);
      exp_wr  <= clken && (avr_char_we || avr_attr_we);
      exp_cwe <= clken && avr_char_we;
      exp_awe <= clken && avr_attr_we;
      exp_wa  <= m_ptr;
      exp_wd  <= avr_wdata;
    end
  end

  // Compare process: pointer every cycle, slot write the cycle after each strobe,
  // and prefetched data against the RAM whenever valid and the engine is quiet.
  always @(negedge clk_pixel) begin
    if (started && !rst) begin
      chk("avr_addr", avr_addr, m_ptr);
      if (exp_wr) begin
        chk("slot_addr", ram_addr, exp_wa);
        chk("slot_char_we", ram_char_we, exp_cwe);
        chk("slot_attr_we", ram_attr_we, exp_awe);
        if (exp_cwe) chk("slot_char_data", ram_char_wdata, exp_wd);
        if (exp_awe) chk("slot_attr_data", ram_attr_wdata, exp_wd);
      end
      if (chk_rd && avr_rd_valid && !busy) begin
        chk("prefetch_char", avr_char_rdata, cmem[avr_addr]);
        chk("prefetch_attr", avr_attr_rdata, amem[avr_addr]);
      end
    end
  end

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic avr(input logic lo, input logic hi, input logic cw, input logic aw,
                     input logic ar, input logic [7:0] d);
    clken = 1'b1; avr_addr_lo_we = lo; avr_addr_hi_we = hi;
    avr_char_we = cw; avr_attr_we = aw; avr_attr_re = ar; avr_wdata = d;
    tick();
    clken = 1'b0; avr_addr_lo_we = 1'b0; avr_addr_hi_we = 1'b0;
    avr_char_we = 1'b0; avr_attr_we = 1'b0; avr_attr_re = 1'b0;
  endtask

  task automatic bd_write(input int a, input logic [7:0] c, input logic [7:0] t);
    bd_we = 1'b1; bd_addr = 13'(a); bd_c = c; bd_a = t;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!avr_rd_valid && n < 12) begin
      tick();
      n++;
    end
    chk(nm, avr_rd_valid, 1);
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 40000) begin
      tick();
      cnt++;
    end
  endtask

  task automatic preload_rows();
    for (int i = 0; i < 2400; i++) bd_write(i, 8'(i / 80), 8'(i / 80 + 8'h40));
  endtask

  task automatic check_scrolled(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < 2400; i++) begin
      if (i < 2320) begin
        if (cmem[i] != 8'(i / 80 + 1) || amem[i] != 8'(i / 80 + 1 + 8'h40)) bad++;
      end else if (cmem[i] != 8'h20 || amem[i] != 8'h07) bad++;
    end
    chk(nm, bad, 0);
  endtask

  int cnt, bad, old500c;
  logic [7:0] last_d;

  initial begin
    // Reset while clearing the visible area plus the off-screen cells used below.
    for (int i = 0; i <= 2500; i++) bd_write(i, 8'h00, 8'h00);
    tick();
    rst = 1'b0;
    started = 1'b1;
    #1;
    chk("rst_addr", avr_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", avr_rd_valid, 0);
    chk("rst_rdata", {avr_char_rdata, avr_attr_rdata}, 0);
    chk("rst_enables", {ram_char_we, ram_attr_we, ram_rden}, 0);

    // 1: pointer 1999, char 0x41, attr 0x1F
    avr(1, 0, 0, 0, 0, 8'hCF);
    avr(0, 1, 0, 0, 0, 8'h07);
    avr(0, 0, 1, 0, 0, 8'h41);
    avr(0, 0, 0, 1, 0, 8'h1F);
    wait_valid("t1_valid_timeout");
    chk("t1_ram_char", cmem[1999], 8'h41);
    chk("t1_ram_attr", amem[1999], 8'h1F);
    chk("t1_ptr", avr_addr, 2000);
    chk("t1_rdata", {avr_char_rdata, avr_attr_rdata}, 0);

    // 2: pointer 2399, attr read wraps to 0
    bd_write(0, 8'h55, 8'hAA);
    avr(1, 0, 0, 0, 0, 8'h5F);
    avr(0, 1, 0, 0, 0, 8'h09);
    chk("t2_ptr_load", avr_addr, 2399);
    avr(0, 0, 0, 0, 1, 8'h00);
    chk("t2_ptr_wrap", avr_addr, 0);
    wait_valid("t2_valid_timeout");
    chk("t2_rdata_char", avr_char_rdata, 8'h55);
    chk("t2_rdata_attr", avr_attr_rdata, 8'hAA);

    // 3: clear-screen fill
    bd_write(2400, 8'h99, 8'h99);
    repeat (3) tick();
    fill_char = 8'h20; fill_attr = 8'h07;
    cmd_fill = 1'b1;
    tick();
    cmd_fill = 1'b0;
    count_busy(cnt);
    chk("t3_fill_cycles", cnt, 2400);
    bad = 0;
    for (int i = 0; i < 2400; i++) if (cmem[i] != 8'h20 || amem[i] != 8'h07) bad++;
    chk("t3_fill_cells_bad", bad, 0);
    chk("t3_cell2400", {cmem[2400], amem[2400]}, 16'h9999);
    wait_valid("t3_valid_after_fill");
    chk("t3_rdata", {avr_char_rdata, avr_attr_rdata}, 16'h2007);

    // 4: uncontended scroll
    chk_rd = 1'b0;
    preload_rows();
    avr(1, 0, 0, 0, 0, 8'h00);
    chk_rd = 1'b1;
    repeat (5) tick();
    cmd_scroll = 1'b1;
    tick();
    cmd_scroll = 1'b0;
    count_busy(cnt);
    chk("t4_scroll_cycles", cnt, 4720);
    check_scrolled("t4_scroll_cells_bad");
    chk("t4_row0_col5", cmem[5], 1);
    chk("t4_row29_col0", {cmem[2320], amem[2320]}, 16'h2007);

    // 5: scroll with an AVR char write every third cycle at off-screen cell 2500
    chk_rd = 1'b0;
    preload_rows();
    avr(1, 0, 0, 0, 0, 8'hC4);
    avr(0, 1, 0, 0, 0, 8'h09);
    chk_rd = 1'b1;
    chk("t5_ptr_unclamped", avr_addr, 2500);
    repeat (5) tick();
    cmd_scroll = 1'b1;
    tick();
    cmd_scroll = 1'b0;
    cnt = 0;
    last_d = '0;
    while (busy && cnt < 40000) begin
      clken       = (cnt % 3 == 0);
      avr_char_we = (cnt % 3 == 0);
      avr_wdata   = 8'(cnt + 1);
      if (cnt % 3 == 0) last_d = 8'(cnt + 1);
      tick();
      cnt++;
    end
    clken = 1'b0; avr_char_we = 1'b0;
    repeat (3) tick();
    chk("t5_busy_stretched", int'(cnt > 4720 && cnt < 40000), 1);
    check_scrolled("t5_scroll_cells_bad");
    chk("t5_last_avr_write", cmem[2500], last_d);

    // 6: fill and scroll together, reset at cycle 100
    old500c = cmem[500];
    fill_char = 8'h2E; fill_attr = 8'h17;
    cmd_fill = 1'b1; cmd_scroll = 1'b1;
    tick();
    cmd_fill = 1'b0; cmd_scroll = 1'b0;
    chk("t6_busy", busy, 1);
    repeat (98) tick();
    chk("t6_fill_taken", {cmem[50], amem[50]}, 16'h2E17);
    rst = 1'b1;
    tick();
    tick();
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ptr", avr_addr, 0);
    chk("t6_rst_valid", avr_rd_valid, 0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (ram_char_we || ram_attr_we) bad++;
      tick();
    end
    chk("t6_no_writes_after_rst", bad, 0);
    chk("t6_partial_cell500", cmem[500], old500c);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
